// File: rtl/ysyx_22041412_axi_pkg.sv
// Shared types and constants for the AXI request arbiter.
// Grant-index width helper keeps a 1-bit index even for a single master.
package ysyx_22041412_axi_pkg;

  localparam int unsigned SIZE_W = 8;
  localparam int unsigned LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  function automatic int unsigned grant_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ysyx_22041412_rr_picker.sv
// Combinational rotating picker: among the asserted requests, grants the one
// closest to i_start going upward with wrap-around. Returns one-hot and index.
module ysyx_22041412_rr_picker
  import ysyx_22041412_axi_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = grant_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_start,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  int unsigned w_best;
  int unsigned w_dist;
  logic        w_found;

  // Pick the requester at the smallest rotational distance from the start.
  always_comb begin
    w_best  = NUM_REQ;
    w_dist  = 0;
    w_found = 1'b0;
    o_idx   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      w_dist = (j + NUM_REQ - 32'(i_start)) % NUM_REQ;
      if (i_req[j] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_idx   = IDX_W'(j);
        w_found = 1'b1;
      end
    end
  end

  // Expand the chosen index to a one-hot grant vector.
  always_comb begin
    o_grant = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      o_grant[j] = w_found && (o_idx == IDX_W'(j));
    end
  end

endmodule

// File: rtl/ysyx_22041412_axi_rr_arbiter.sv
// N-master arbiter in front of the single AXI read/write bridge.
// One whole transaction at a time: the winner's request is latched, presented
// to the bridge, and completion (plus read data) is returned to that master.
// Selection: ARB_RR_EN defined -> round-robin (search from last grant + 1);
//            undefined        -> fixed priority, highest index wins.
module ysyx_22041412_axi_rr_arbiter
  import ysyx_22041412_axi_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ADDR_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  // master side
  input  logic [NUM_MASTERS-1:0]                m_valid,
  input  logic [NUM_MASTERS-1:0]                m_wen,
  input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS*SIZE_W-1:0]         m_size,
  input  logic [NUM_MASTERS*LEN_W-1:0]          m_len,
  output logic [NUM_MASTERS-1:0]                m_ready,
  output logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0] m_rdata,
  // bridge side
  output logic                                r_valid,
  output logic                                w_valid,
  input  logic                                r_done,
  input  logic                                w_done,
  input  logic [AXI_DATA_WIDTH-1:0]           r_data,
  output logic [AXI_ADDR_WIDTH-1:0]           r_addr,
  output logic [AXI_ADDR_WIDTH-1:0]           w_addr,
  output logic [AXI_DATA_WIDTH-1:0]           w_data,
  output logic [SIZE_W-1:0]                   r_size,
  output logic [SIZE_W-1:0]                   w_size,
  output logic [LEN_W-1:0]                    r_len,
  output logic [LEN_W-1:0]                    w_len
);

  localparam int unsigned IDX_W = grant_idx_w(NUM_MASTERS);
  localparam int unsigned AW    = AXI_ADDR_WIDTH;
  localparam int unsigned DW    = AXI_DATA_WIDTH;

  arb_state_e r_state;
  arb_state_e w_state_nxt;

  logic [IDX_W-1:0]  r_gnt_idx;
  logic              r_lat_wen;
  logic [AW-1:0]     r_lat_addr;
  logic [DW-1:0]     r_lat_wdata;
  logic [SIZE_W-1:0] r_lat_size;
  logic [LEN_W-1:0]  r_lat_len;
  logic [NUM_MASTERS*DW-1:0] r_rdata;

  logic [IDX_W-1:0]  w_win_idx;
  logic              w_any_req;
  logic              w_grant;
  logic              w_done_match;
  logic              w_rd_cmpl;

  logic              w_sel_wen;
  logic [AW-1:0]     w_sel_addr;
  logic [DW-1:0]     w_sel_wdata;
  logic [SIZE_W-1:0] w_sel_size;
  logic [LEN_W-1:0]  w_sel_len;

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
`ifdef ARB_RR_EN
  logic [IDX_W-1:0]       r_rr_last;
  logic [IDX_W-1:0]       w_rr_start;
  logic [NUM_MASTERS-1:0] w_pick_onehot;

  // Search begins one past the most recent grant, wrapping at NUM_MASTERS.
  always_comb begin
    if (32'(r_rr_last) >= NUM_MASTERS - 1) begin
      w_rr_start = '0;
    end else begin
      w_rr_start = r_rr_last + IDX_W'(1);
    end
  end

  ysyx_22041412_rr_picker #(
    .NUM_REQ (NUM_MASTERS),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req   (m_valid),
    .i_start (w_rr_start),
    .o_grant (w_pick_onehot),
    .o_idx   (w_win_idx)
  );

  assign w_any_req = |w_pick_onehot;

  // Remember the last granted master; reset value 0 makes master 1 go first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last <= '0;
    end else if (w_grant) begin
      r_rr_last <= w_win_idx;
    end
  end
`else
  // Fixed priority: later (higher) indices overwrite earlier ones.
  always_comb begin
    w_win_idx = '0;
    for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
      if (m_valid[j]) begin
        w_win_idx = IDX_W'(j);
      end
    end
  end

  assign w_any_req = |m_valid;
`endif

  assign w_grant = (r_state == ST_IDLE) && w_any_req;

  // Mux the winning master's request fields out of the packed input buses.
  always_comb begin
    w_sel_wen   = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_size  = '0;
    w_sel_len   = '0;
    for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
      if (IDX_W'(j) == w_win_idx) begin
        w_sel_wen   = m_wen[j];
        w_sel_addr  = m_addr[j*AW +: AW];
        w_sel_wdata = m_wdata[j*DW +: DW];
        w_sel_size  = m_size[j*SIZE_W +: SIZE_W];
        w_sel_len   = m_len[j*LEN_W +: LEN_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM
  // ---------------------------------------------------------------------------
  assign w_done_match = r_lat_wen ? w_done : r_done;
  assign w_rd_cmpl    = (r_state == ST_BUSY) && !r_lat_wen && r_done;

  // State register; reset aborts any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: grant in IDLE, wait for the matching done, one RESP cycle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_any_req) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_done_match) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: direction-qualified valid in BUSY, one-hot ready in RESP.
  always_comb begin
    r_valid = (r_state == ST_BUSY) && !r_lat_wen;
    w_valid = (r_state == ST_BUSY) &&  r_lat_wen;
    m_ready = '0;
    for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
      m_ready[j] = (r_state == ST_RESP) && (r_gnt_idx == IDX_W'(j));
    end
  end

  // ---------------------------------------------------------------------------
  // Request latch and per-master read data
  // ---------------------------------------------------------------------------

  // Capture the winner's request at grant; held untouched until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_idx   <= '0;
      r_lat_wen   <= 1'b0;
      r_lat_addr  <= '0;
      r_lat_wdata <= '0;
      r_lat_size  <= '0;
      r_lat_len   <= '0;
    end else if (w_grant) begin
      r_gnt_idx   <= w_win_idx;
      r_lat_wen   <= w_sel_wen;
      r_lat_addr  <= w_sel_addr;
      r_lat_wdata <= w_sel_wdata;
      r_lat_size  <= w_sel_size;
      r_lat_len   <= w_sel_len;
    end
  end

  // Store bridge read data into the granted master's slice on read completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_rd_cmpl) begin
      for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
        if (r_gnt_idx == IDX_W'(j)) begin
          r_rdata[j*DW +: DW] <= r_data;
        end
      end
    end
  end

  assign m_rdata = r_rdata;
  assign r_addr  = r_lat_addr;
  assign w_addr  = r_lat_addr;
  assign w_data  = r_lat_wdata;
  assign r_size  = r_lat_size;
  assign w_size  = r_lat_size;
  assign r_len   = r_lat_len;
  assign w_len   = r_lat_len;

endmodule

// File: tb/tb_ysyx_22041412_axi_rr_arbiter.sv
// Bench for the AXI request arbiter: directed scenarios followed by random
// master/bridge traffic compared against a transaction-level reference model.
module tb_ysyx_22041412_axi_rr_arbiter;

  localparam int NM = 2;

  logic           clk;
  logic           rst_n;
  logic [1:0]     m_valid, m_wen, m_ready;
  logic [63:0]    m_addr;
  logic [127:0]   m_wdata, m_rdata;
  logic [15:0]    m_size, m_len;
  logic           r_valid, w_valid, r_done, w_done;
  logic [63:0]    r_data, w_data;
  logic [31:0]    r_addr, w_addr;
  logic [7:0]     r_size, w_size, r_len, w_len;

  int total = 0;
  int bad   = 0;

  ysyx_22041412_axi_rr_arbiter #(
    .NUM_MASTERS    (2),
    .AXI_DATA_WIDTH (64),
    .AXI_ADDR_WIDTH (32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_size(m_size), .m_len(m_len), .m_ready(m_ready), .m_rdata(m_rdata),
    .r_valid(r_valid), .w_valid(w_valid), .r_done(r_done), .w_done(w_done),
    .r_data(r_data), .r_addr(r_addr), .w_addr(w_addr), .w_data(w_data),
    .r_size(r_size), .w_size(w_size), .r_len(r_len), .w_len(w_len)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state (transaction level)
  bit          md_busy, md_resp, md_wen;
  int          md_g, md_last;
  logic [31:0] ex_addr;
  logic [63:0] ex_wdata;
  logic [7:0]  ex_size, ex_len;
  logic [63:0] ex_rdata [NM];

  function automatic int pick(input logic [1:0] v, input int last);
    int  w;
    bit  found;
    w = 0;
    found = 0;
`ifdef ARB_RR_EN
    for (int k = 1; k <= NM; k++) begin
      int j;
      j = (last + k) % NM;
      if (!found && v[j]) begin
        w = j;
        found = 1;
      end
    end
`else
    for (int j = NM - 1; j >= 0; j--) begin
      if (!found && v[j]) begin
        w = j;
        found = 1;
      end
    end
`endif
    return w;
  endfunction

  task automatic new_req(input int i);
    m_valid[i]          = 1'b1;
    m_wen[i]            = 1'($urandom_range(0, 1));
    m_addr[i*32 +: 32]  = $urandom;
    m_wdata[i*64 +: 64] = {$urandom, $urandom};
    m_size[i*8 +: 8]    = 8'($urandom_range(0, 255));
    m_len[i*8 +: 8]     = 8'($urandom_range(0, 255));
  endtask

  logic [1:0] exp_g [4];
  int         got_g [$];
  int         released;

  initial begin
`ifdef ARB_RR_EN
    exp_g[0] = 2'd1; exp_g[1] = 2'd0; exp_g[2] = 2'd1; exp_g[3] = 2'd0;
`else
    exp_g[0] = 2'd1; exp_g[1] = 2'd1; exp_g[2] = 2'd1; exp_g[3] = 2'd1;
`endif
    rst_n = 1'b0;
    m_valid = '0; m_wen = '0; m_addr = '0; m_wdata = '0; m_size = '0; m_len = '0;
    r_done = 1'b0; w_done = 1'b0; r_data = '0;

    // ---- reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rvalid", r_valid, 1'b0);
    check("rst_wvalid", w_valid, 1'b0);
    check("rst_mready", m_ready, 2'b00);
    check("rst_rdata", m_rdata, 128'h0);
    check("rst_raddr", r_addr, 32'h0);
    check("rst_wdata", w_data, 64'h0);
    rst_n = 1'b1;

    // ---- single IF read, with input change and wrong-direction done in BUSY
    tick();
    m_valid = 2'b01; m_wen = 2'b00;
    m_addr[31:0] = 32'h8000_0000; m_size[7:0] = 8'd3; m_len[7:0] = 8'd0;
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) m_addr[31:0] = 32'h0;
      w_done = (c == 3);
      if (c == 4) begin
        r_done = 1'b1;
        r_data = 64'hDEAD_BEEF_0000_0013;
      end
      @(negedge clk);
      check("rd_rvalid", r_valid, 1'b1);
      check("rd_wvalid", w_valid, 1'b0);
      check("rd_raddr", r_addr, 32'h8000_0000);
      check("rd_mready_busy", m_ready, 2'b00);
      tick();
    end
    r_done = 1'b0;
    @(negedge clk);
    check("rd_mready", m_ready, 2'b01);
    check("rd_rvalid_resp", r_valid, 1'b0);
    tick();
    m_valid = 2'b00;
    @(negedge clk);
    check("rd_mready_end", m_ready, 2'b00);
    check("rd_rdata", m_rdata, {64'h0, 64'hDEAD_BEEF_0000_0013});
    check("rd_raddr_hold", r_addr, 32'h8000_0000);

    // ---- MEM write, done in the same cycle valid rises
    tick();
    m_valid = 2'b10; m_wen = 2'b10;
    m_addr[63:32] = 32'h8000_1000; m_wdata[127:64] = 64'h1122_3344_5566_7788;
    m_size[15:8] = 8'd3; m_len[15:8] = 8'd0;
    tick();
    w_done = 1'b1;
    @(negedge clk);
    check("wr_wvalid", w_valid, 1'b1);
    check("wr_rvalid", r_valid, 1'b0);
    check("wr_waddr", w_addr, 32'h8000_1000);
    check("wr_wdata", w_data, 64'h1122_3344_5566_7788);
    check("wr_wsize", w_size, 8'd3);
    check("wr_wlen", w_len, 8'd0);
    tick();
    w_done = 1'b0;
    @(negedge clk);
    check("wr_mready", m_ready, 2'b10);
    check("wr_wvalid_resp", w_valid, 1'b0);
    tick();
    m_valid = 2'b00; m_wen = 2'b00;
    @(negedge clk);
    check("wr_rdata_keep", m_rdata, {64'h0, 64'hDEAD_BEEF_0000_0013});

    // ---- contention from a fresh reset (pointer at 0)
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    m_valid = 2'b11; m_wen = 2'b00;
    m_addr = {32'h0000_00BB, 32'h0000_00AA};
    r_done = 1'b1; r_data = 64'h55;
    for (int c = 0; c < 14; c++) begin
      tick();
      @(negedge clk);
      if (r_valid) got_g.push_back((r_addr == 32'h0000_00BB) ? 1 : 0);
    end
    check("cont_count_ok", got_g.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i < got_g.size()) check($sformatf("cont_grant%0d", i), got_g[i], exp_g[i]);
    end
    m_valid = 2'b00;
    repeat (4) tick();
    r_done = 1'b0;

    // ---- reset in the middle of BUSY
    m_valid = 2'b01; m_wen = 2'b00; m_addr[31:0] = 32'h0000_0C00;
    tick();
    @(negedge clk);
    check("mid_rvalid_pre", r_valid, 1'b1);
    check("mid_rdata_pre_nz", m_rdata != 128'h0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rvalid", r_valid, 1'b0);
    check("mid_mready", m_ready, 2'b00);
    check("mid_rdata", m_rdata, 128'h0);
    m_valid = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rvalid_post", r_valid, 1'b0);
    check("mid_mready_post", m_ready, 2'b00);

    // ---- random traffic vs reference model (DUT freshly reset, idle)
    md_busy = 0; md_resp = 0; md_wen = 0; md_g = 0; md_last = 0;
    ex_addr = '0; ex_wdata = '0; ex_size = '0; ex_len = '0;
    ex_rdata[0] = '0; ex_rdata[1] = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      // advance model with what the DUT just sampled
      released = -1;
      if (md_resp) begin
        md_resp  = 0;
        released = md_g;
      end else if (md_busy) begin
        if (md_wen ? w_done : r_done) begin
          md_busy = 0;
          md_resp = 1;
          if (!md_wen) ex_rdata[md_g] = r_data;
        end
      end else if (m_valid != 2'b00) begin
        md_g     = pick(m_valid, md_last);
        md_last  = md_g;
        md_busy  = 1;
        md_wen   = m_wen[md_g];
        ex_addr  = m_addr[md_g*32 +: 32];
        ex_wdata = m_wdata[md_g*64 +: 64];
        ex_size  = m_size[md_g*8 +: 8];
        ex_len   = m_len[md_g*8 +: 8];
      end
      // drive masters
      for (int i = 0; i < NM; i++) begin
        if (released == i) begin
          if ($urandom_range(0, 1) == 1) new_req(i);
          else m_valid[i] = 1'b0;
        end else if (!m_valid[i]) begin
          if ($urandom_range(0, 3) == 0) new_req(i);
        end else if (md_busy && $urandom_range(0, 5) == 0) begin
          m_addr[i*32 +: 32]  = $urandom;
          m_wdata[i*64 +: 64] = {$urandom, $urandom};
        end
      end
      // drive bridge (done pulses arrive in any state)
      r_done = ($urandom_range(0, 2) == 0);
      w_done = ($urandom_range(0, 2) == 0);
      r_data = {$urandom, $urandom};
      @(negedge clk);
      check("rnd_rvalid", r_valid, md_busy && !md_wen);
      check("rnd_wvalid", w_valid, md_busy && md_wen);
      check("rnd_mready", m_ready, md_resp ? (2'b01 << md_g) : 2'b00);
      check("rnd_raddr", r_addr, ex_addr);
      check("rnd_waddr", w_addr, ex_addr);
      check("rnd_wdata", w_data, ex_wdata);
      check("rnd_size", {r_size, w_size}, {ex_size, ex_size});
      check("rnd_len", {r_len, w_len}, {ex_len, ex_len});
      check("rnd_rdata", m_rdata, {ex_rdata[1], ex_rdata[0]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22041412_axi_rr_arbiter.md
# ysyx_22041412_axi_rr_arbiter

Parametrised N-master arbiter between the core's memory requesters (IF, MEM, future DMA/debug) and the single AXI read/write bridge. It grants one whole transaction at a time and latches the granted request into stable outputs for the bridge's duration. It returns read data and a one-cycle completion pulse to the granted master only. Round-robin or fixed-priority selection is chosen at compile time.

## Interface
- NUM_MASTERS, 2, number of requesters; index 0 = IF, highest index = MEM by convention
- AXI_DATA_WIDTH, 64, data width
- AXI_ADDR_WIDTH, 32, address width
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- m_valid  in  NUM_MASTERS  per-master request; held until that master's m_ready
- m_wen  in  NUM_MASTERS  1 = write, 0 = read
- m_addr  in  NUM_MASTERS*AXI_ADDR_WIDTH  request address, master i at slice i
- m_wdata  in  NUM_MASTERS*AXI_DATA_WIDTH  write data
- m_size  in  NUM_MASTERS*8  transfer size
- m_len  in  NUM_MASTERS*8  burst length
- m_ready  out  NUM_MASTERS  one-cycle completion pulse, one-hot
- m_rdata  out  NUM_MASTERS*AXI_DATA_WIDTH  per-master read-data register
- r_valid  out  1  read request to bridge
- w_valid  out  1  write request to bridge
- r_done  in  1  bridge read complete, data valid on r_data
- w_done  in  1  bridge write complete
- r_data  in  AXI_DATA_WIDTH  bridge read data
- r_addr / w_addr  out  AXI_ADDR_WIDTH each  latched address
- w_data  out  AXI_DATA_WIDTH  latched write data
- r_size / w_size / r_len / w_len  out  8 each  latched size/len

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any m_valid, pick winner g; latch wen, addr, wdata, size, len of g; store g; go BUSY. No valid: stay.
- BUSY: drive r_valid (wen=0) or w_valid (wen=1) from the latch; the other valid stays 0. Latched fields never change in BUSY. Ignore changes on m_* inputs.
  - Wait for r_done (read) or w_done (write).
  - The done of the wrong direction is ignored.
  - On matching done:
    - drop valid;
    - for a read, copy r_data into m_rdata slice g;
    - go RESP.
- RESP: m_ready[g]=1 for exactly this cycle; go IDLE. m_valid is not sampled in RESP.
- m_rdata slices hold their value until the next read completed for that master; writes never modify them.
- Output fields r_addr/w_addr etc. keep last latched value in IDLE (not cleared); only valids qualify them.
- Done inputs in IDLE or RESP are ignored.
- Grant index width: $clog2(NUM_MASTERS), minimum 1. NUM_MASTERS=1 is legal: always grant 0.

## Timing
- Reset (async assert, sync-safe deassert by upstream): state IDLE, r_valid=w_valid=0, m_ready=0, all m_rdata=0, all latched fields 0, RR pointer = 0.
- Reset mid-BUSY aborts immediately. No m_ready is issued.
- Latency: m_valid sampled in IDLE at edge 0 → r_valid/w_valid high from cycle 1. Done seen at edge k → m_ready high in cycle k+1. IDLE again at k+2. Next grant sampled at edge k+2, with its valid out at k+3.
- Done in the same cycle as valid rises (cycle 1) is legal: m_ready in cycle 2.
- Masters must deassert m_valid (or present a new request) in the cycle after m_ready. A still-high valid in IDLE is treated as a new request.

## Configuration
- ARB_RR_EN defined: round-robin. Search starts at (last grant + 1) mod NUM_MASTERS. The pointer updates on every grant.
- ARB_RR_EN undefined: fixed priority, highest index wins (MEM over IF). The pointer logic is not built.

## Structure
- Package ysyx_22041412_axi_pkg: FSM state enum, SIZE_W=8, LEN_W=8 constants, grant-index width helper.
- Sub-module ysyx_22041412_rr_picker: combinational, takes request vector + start pointer, returns one-hot grant and index. It is instantiated only under ARB_RR_EN.

## Test plan
- Reset: rst_n low mid-BUSY with r_valid=1 → r_valid=0 and state IDLE immediately. No m_ready. m_rdata all 0.
- Single IF read: m_valid=01, m_addr[0]=0x8000_0000, bridge r_done at cycle 4 with r_data=0xDEAD_BEEF_0000_0013. Required response:
  - r_valid cycles 1–4, r_addr=0x8000_0000;
  - m_ready=01 in cycle 5;
  - m_rdata[0]=0xDEAD_BEEF_0000_0013.
- MEM write: wen=1, addr 0x8000_1000, wdata 0x1122_3344_5566_7788, size 3 → w_valid with exact fields, r_valid=0. m_ready=10 after w_done. m_rdata[1] unchanged.
- Contention, ARB_RR_EN, both masters continuously valid → grants alternate 1,0,1,0 (pointer 0 start). Without the macro → grants all to 1 while it stays valid.
- Input change in BUSY: change m_addr[g] to 0x0 after cycle 1 → r_addr stays at the original value until done.
- Wrong-direction done: read in BUSY, pulse w_done → no effect. Later r_done completes normally.
